// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus a 32-step shift-add multiplier.
// Produces a registered write-back triple for the register bank and keeps
// Z/N/C/V condition flags for the branch logic.
module exec_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] dest,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v,
    output logic              illegal
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SAR  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10,
        OP_MOV  = 4'd11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [DATA_W-1:0]   w_b;
    logic [SH_W-1:0]     w_shamt;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_result;
    logic                w_c;
    logic                w_v;
    logic                w_accept;
    logic                w_illegal;
    logic                w_is_mul;
    logic                w_mul_last;

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_mul_dest;
    logic [2*DATA_W-1:0] w_acc_next;

    logic                r_wb_en;
    logic [ADDR_W-1:0]   r_wb_addr;
    logic [DATA_W-1:0]   r_wb_data;
    logic                r_z, r_n, r_c, r_v;
    logic                r_illegal;

    assign w_b        = use_imm ? imm : op_b;
    assign w_shamt    = w_b[SH_W-1:0];
    assign w_sum      = {1'b0, op_a} + {1'b0, w_b};
    assign w_diff     = op_a - w_b;
    assign issue_ready = (r_state == S_IDLE) && !rst;
    assign w_accept   = issue_valid && issue_ready;
    assign w_illegal  = (op >= 4'd12) || (32'(dest) >= 32'(NUM_REGS));
    assign w_is_mul   = (op == OP_MUL);
    assign w_mul_last = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle ALU result and the arithmetic carry/overflow terms.
    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (op)
            OP_ADD: begin
                w_result = w_sum[DATA_W-1:0];
                w_c      = w_sum[DATA_W];
                w_v      = (op_a[DATA_W-1] == w_b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                w_result = w_diff;
                w_c      = (op_a < w_b);
                w_v      = (op_a[DATA_W-1] != w_b[DATA_W-1]) &&
                           (w_diff[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND:  w_result = op_a & w_b;
            OP_OR:   w_result = op_a | w_b;
            OP_XOR:  w_result = op_a ^ w_b;
            OP_SHL:  w_result = op_a << w_shamt;
            OP_SHR:  w_result = op_a >> w_shamt;
            OP_SAR:  w_result = DATA_W'($signed(op_a) >>> w_shamt);
            OP_SLT:  w_result = DATA_W'($signed(op_a) < $signed(w_b));
            OP_SLTU: w_result = DATA_W'(op_a < w_b);
            OP_MOV:  w_result = w_b;
            default: w_result = '0;
        endcase
    end

    // Next-state: legal MUL enters the multiply loop, step 31 leaves it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mul && !w_illegal) w_state_next = S_MUL;
            S_MUL:  if (w_mul_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Write-back, flags, illegal pulse and multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_c        <= 1'b0;
            r_v        <= 1'b0;
            r_illegal  <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_mul_dest <= '0;
        end else begin
            r_wb_en   <= 1'b0;
            r_illegal <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (w_illegal) begin
                        r_illegal <= 1'b1;
                    end else if (w_is_mul) begin
                        r_acc      <= '0;
                        r_mcand    <= {{DATA_W{1'b0}}, op_a};
                        r_mplier   <= w_b;
                        r_cnt      <= '0;
                        r_mul_dest <= dest;
                    end else begin
                        r_wb_en   <= 1'b1;
                        r_wb_addr <= dest;
                        r_wb_data <= w_result;
                        r_z       <= (w_result == '0);
                        r_n       <= w_result[DATA_W-1];
                        r_c       <= w_c;
                        r_v       <= w_v;
                    end
                end
            end else begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                // Final step writes back straight from the adder output.
                if (w_mul_last) begin
                    r_wb_en   <= 1'b1;
                    r_wb_addr <= r_mul_dest;
                    r_wb_data <= w_acc_next[DATA_W-1:0];
                    r_z       <= (w_acc_next[DATA_W-1:0] == '0);
                    r_n       <= w_acc_next[DATA_W-1];
                    r_c       <= |w_acc_next[2*DATA_W-1:DATA_W];
                    r_v       <= 1'b0;
                end
            end
        end
    end

    assign wb_en   = r_wb_en;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;
    assign flag_z  = r_z;
    assign flag_n  = r_n;
    assign flag_c  = r_c;
    assign flag_v  = r_v;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_exec_stage.sv
// Directed testbench for exec_stage with hand-computed expected values.
module tb_exec_stage;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  op;
    logic [7:0]  dest;
    logic        use_imm;
    logic [31:0] imm;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        wb_en;
    logic [7:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        illegal;

    int unsigned n_checks;
    int unsigned n_errors;

    exec_stage #(.DATA_W(32), .ADDR_W(8), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op(op), .dest(dest), .use_imm(use_imm), .imm(imm),
        .op_a(op_a), .op_b(op_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [7:0] d, input logic ui,
                         input logic [31:0] im, input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        op = o; dest = d; use_imm = ui; imm = im; op_a = a; op_b = b;
    endtask

    function automatic logic [3:0] flags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    // Back-to-back table: op, A, B, expected result
    logic [3:0]  t_op  [10];
    logic [31:0] t_a   [10];
    logic [31:0] t_b   [10];
    logic [31:0] t_exp [10];

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; issue_valid = 1'b0;
        op = '0; dest = '0; use_imm = 1'b0; imm = '0; op_a = '0; op_b = '0;

        t_op[0] = 4'd0;  t_a[0] = 32'd1;          t_b[0] = 32'd2;          t_exp[0] = 32'd3;
        t_op[1] = 4'd4;  t_a[1] = 32'hF0F0F0F0;   t_b[1] = 32'hFF00FF00;   t_exp[1] = 32'h0FF00FF0;
        t_op[2] = 4'd5;  t_a[2] = 32'd3;          t_b[2] = 32'h21;         t_exp[2] = 32'd6;
        t_op[3] = 4'd7;  t_a[3] = 32'h80000000;   t_b[3] = 32'd4;          t_exp[3] = 32'hF8000000;
        t_op[4] = 4'd8;  t_a[4] = 32'hFFFFFFFF;   t_b[4] = 32'd1;          t_exp[4] = 32'd1;
        t_op[5] = 4'd9;  t_a[5] = 32'hFFFFFFFF;   t_b[5] = 32'd1;          t_exp[5] = 32'd0;
        t_op[6] = 4'd11; t_a[6] = 32'h11111111;   t_b[6] = 32'hDEADBEEF;   t_exp[6] = 32'hDEADBEEF;
        t_op[7] = 4'd2;  t_a[7] = 32'hFF00FF00;   t_b[7] = 32'h0F0F0F0F;   t_exp[7] = 32'h0F000F00;
        t_op[8] = 4'd3;  t_a[8] = 32'h12340000;   t_b[8] = 32'h00005678;   t_exp[8] = 32'h12345678;
        t_op[9] = 4'd6;  t_a[9] = 32'h80000000;   t_b[9] = 32'd4;          t_exp[9] = 32'h08000000;

        // Reset state
        tick(); tick();
        check("rst_ready", issue_ready, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_flags", flags(), 0);
        check("rst_illegal", illegal, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", issue_ready, 1);

        // ADD wrap to zero
        drive(4'd0, 8'd3, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd1);
        tick(); issue_valid = 1'b0;
        check("add_wb_en", wb_en, 1);
        check("add_wb_addr", wb_addr, 3);
        check("add_wb_data", wb_data, 0);
        check("add_flags", flags(), 4'b1010);

        // SUB with immediate; op_b deliberately different
        drive(4'd1, 8'd2, 1'b1, 32'd7, 32'd5, 32'd100);
        tick(); issue_valid = 1'b0;
        check("sub_imm_wb_en", wb_en, 1);
        check("sub_imm_data", wb_data, 32'hFFFFFFFE);
        check("sub_imm_flags", flags(), 4'b0110);

        // SUB signed overflow
        drive(4'd1, 8'd2, 1'b0, 32'd0, 32'h80000000, 32'd1);
        tick(); issue_valid = 1'b0;
        check("sub_ovf_data", wb_data, 32'h7FFFFFFF);
        check("sub_ovf_flags", flags(), 4'b0001);

        // Illegal opcode
        drive(4'd13, 8'd1, 1'b0, 32'd0, 32'd9, 32'd9);
        tick(); issue_valid = 1'b0;
        check("ill_op_pulse", illegal, 1);
        check("ill_op_wb_en", wb_en, 0);
        check("ill_op_flags", flags(), 4'b0001);
        check("ill_op_wb_addr_hold", wb_addr, 2);
        check("ill_op_wb_data_hold", wb_data, 32'h7FFFFFFF);
        tick();
        check("ill_op_pulse_end", illegal, 0);

        // Illegal destination
        drive(4'd0, 8'h10, 1'b0, 32'd0, 32'd0, 32'd0);
        tick(); issue_valid = 1'b0;
        check("ill_dest_pulse", illegal, 1);
        check("ill_dest_wb_en", wb_en, 0);
        check("ill_dest_flags", flags(), 4'b0001);

        // Illegal MUL must not stall the stage
        drive(4'd10, 8'h20, 1'b0, 32'd0, 32'd3, 32'd3);
        tick(); issue_valid = 1'b0;
        check("ill_mul_pulse", illegal, 1);
        check("ill_mul_ready", issue_ready, 1);

        // MUL with overflow into the high half; ADD held pending
        drive(4'd10, 8'd5, 1'b0, 32'd0, 32'h00010000, 32'h00010000);
        tick();
        drive(4'd0, 8'd7, 1'b0, 32'd0, 32'd1, 32'd1);
        for (int i = 1; i <= 32; i++) begin
            check($sformatf("mul_busy_ready_%0d", i), issue_ready, 0);
            check($sformatf("mul_busy_wb_en_%0d", i), wb_en, 0);
            tick();
        end
        check("mul1_wb_en", wb_en, 1);
        check("mul1_wb_addr", wb_addr, 5);
        check("mul1_wb_data", wb_data, 0);
        check("mul1_flags", flags(), 4'b1010);
        check("mul1_ready", issue_ready, 1);
        tick(); issue_valid = 1'b0;
        check("held_add_wb_en", wb_en, 1);
        check("held_add_wb_addr", wb_addr, 7);
        check("held_add_wb_data", wb_data, 2);

        // MUL 123*456
        drive(4'd10, 8'd6, 1'b0, 32'd0, 32'd123, 32'd456);
        tick(); issue_valid = 1'b0;
        for (int i = 1; i <= 32; i++) tick();
        check("mul2_wb_en", wb_en, 1);
        check("mul2_wb_data", wb_data, 32'd56088);
        check("mul2_flags", flags(), 4'b0000);

        // Ten back-to-back ops
        for (int i = 0; i < 10; i++) begin
            drive(t_op[i], 8'(i + 1), 1'b0, 32'd0, t_a[i], t_b[i]);
            tick();
            check($sformatf("b2b_wb_en_%0d", i), wb_en, 1);
            check($sformatf("b2b_wb_addr_%0d", i), wb_addr, 64'(i + 1));
            check($sformatf("b2b_wb_data_%0d", i), wb_data, t_exp[i]);
        end
        issue_valid = 1'b0;
        tick();
        check("b2b_idle_wb_en", wb_en, 0);

        // Reset at MUL step 10
        drive(4'd10, 8'd6, 1'b0, 32'd0, 32'd3, 32'd4);
        tick(); issue_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_ready", issue_ready, 0);
        rst = 1'b1;
        #1;
        check("abort_rst_ready", issue_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_ready", issue_ready, 1);
        check("abort_wb_en", wb_en, 0);
        check("abort_wb_addr", wb_addr, 0);
        check("abort_wb_data", wb_data, 0);
        check("abort_flags", flags(), 0);
        check("abort_illegal", illegal, 0);
        drive(4'd0, 8'd4, 1'b0, 32'd0, 32'd2, 32'd2);
        tick(); issue_valid = 1'b0;
        check("post_abort_add_wb_en", wb_en, 1);
        check("post_abort_add_addr", wb_addr, 4);
        check("post_abort_add_data", wb_data, 4);
        begin
            int unsigned stray;
            stray = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (wb_en) stray++;
            end
            check("abort_no_late_wb", stray, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
